// File: rtl/cmul_pkg.sv
// Shared widths and stage sideband type for the streaming complex multiplier.
`timescale 1ns/1ps
package cmul_pkg;

  // Widest tag any instance may carry; narrower tags use the low bits.
  localparam int TAG_MAX_W = 32;

  // Product width for signed DATA x TWID, and the guard-bit sum width.
  function automatic int prod_w(input int data_w, input int twid_w);
    return data_w + twid_w;
  endfunction

  function automatic int sum_w(input int data_w, input int twid_w);
    return prod_w(data_w, twid_w) + 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 conj;
    logic [TAG_MAX_W-1:0] tag;
  } stage_sb_t;

endpackage

// File: rtl/cmul_round_sat.sv
// Round-half-up, arithmetic shift right and saturate one SUM_W component to OUT_W.
`timescale 1ns/1ps
module cmul_round_sat #(
  parameter int IN_W  = 38,
  parameter int OUT_W = 21,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // One extra bit so the rounding constant can never wrap the sum.
  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shf;

  assign ext = EXT_W'(din);

  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
    assign rnd = ext + HALF;
  end else begin : g_nornd
    assign rnd = ext;
  end

  assign shf = rnd >>> SHIFT;

  always_comb begin
    sat  = 1'b0;
    dout = shf[OUT_W-1:0];
    if (shf > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shf < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/complex_mul_rs.sv
// Three-stage streaming complex multiplier (a*b or a*conj(b)) with round/shift/saturate,
// a single global advance enable for backpressure, a tag sideband and a sticky overflow flag.
`timescale 1ns/1ps
module complex_mul_rs
  import cmul_pkg::*;
#(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int OUT_WIDTH  = 21,
  parameter int SHIFT      = 15,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         conj_b,
  input  logic signed [DATA_WIDTH-1:0] a_r,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [TWID_WIDTH-1:0] b_r,
  input  logic signed [TWID_WIDTH-1:0] b_i,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  c_r,
  output logic signed [OUT_WIDTH-1:0]  c_i,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         out_sat,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr
);

  localparam int PROD_W = prod_w(DATA_WIDTH, TWID_WIDTH);
  localparam int SUM_W  = sum_w(DATA_WIDTH, TWID_WIDTH);

  stage_sb_t sb1_q, sb1_d, sb2_q, sb2_d;
  logic signed [PROD_W-1:0]    p_rr_q, p_rr_d, p_ii_q, p_ii_d;
  logic signed [PROD_W-1:0]    p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic signed [SUM_W-1:0]     re_q, re_d, im_q, im_d;
  logic signed [OUT_WIDTH-1:0] c_r_q, c_r_d, c_i_q, c_i_d;
  logic [TAG_WIDTH-1:0]        out_tag_q, out_tag_d;
  logic                        out_sat_q, out_sat_d;
  logic                        out_valid_q, out_valid_d;
  logic                        ovf_sticky_q, ovf_sticky_d;

  logic signed [OUT_WIDTH-1:0] re_rs, im_rs;
  logic                        re_sat, im_sat;
  logic                        en;
  logic                        unused_sb;

  // The whole pipe moves as one; a held output freezes every stage behind it.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  cmul_round_sat #(.IN_W(SUM_W), .OUT_W(OUT_WIDTH), .SHIFT(SHIFT)) u_rs_re (
    .din  (re_q),
    .dout (re_rs),
    .sat  (re_sat)
  );

  cmul_round_sat #(.IN_W(SUM_W), .OUT_W(OUT_WIDTH), .SHIFT(SHIFT)) u_rs_im (
    .din  (im_q),
    .dout (im_rs),
    .sat  (im_sat)
  );

  always_comb begin
    sb1_d       = sb1_q;
    sb2_d       = sb2_q;
    p_rr_d      = p_rr_q;
    p_ii_d      = p_ii_q;
    p_ri_d      = p_ri_q;
    p_ir_d      = p_ir_q;
    re_d        = re_q;
    im_d        = im_q;
    c_r_d       = c_r_q;
    c_i_d       = c_i_q;
    out_tag_d   = out_tag_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (en) begin
      sb1_d.valid              = in_valid;
      sb1_d.conj               = conj_b;
      sb1_d.tag                = '0;
      sb1_d.tag[TAG_WIDTH-1:0] = in_tag;
      p_rr_d = PROD_W'(a_r) * PROD_W'(b_r);
      p_ii_d = PROD_W'(a_i) * PROD_W'(b_i);
      p_ri_d = PROD_W'(a_r) * PROD_W'(b_i);
      p_ir_d = PROD_W'(a_i) * PROD_W'(b_r);

      sb2_d = sb1_q;
      if (sb1_q.conj) begin
        re_d = SUM_W'(p_rr_q) + SUM_W'(p_ii_q);
        im_d = SUM_W'(p_ir_q) - SUM_W'(p_ri_q);
      end else begin
        re_d = SUM_W'(p_rr_q) - SUM_W'(p_ii_q);
        im_d = SUM_W'(p_ri_q) + SUM_W'(p_ir_q);
      end

      c_r_d       = re_rs;
      c_i_d       = im_rs;
      out_sat_d   = re_sat | im_sat;
      out_tag_d   = sb2_q.tag[TAG_WIDTH-1:0];
      out_valid_d = sb2_q.valid;
    end
    // Clear wins over a coincident saturated delivery.
    ovf_sticky_d = ovf_clr ? 1'b0 : (ovf_sticky_q | (out_valid_q & out_ready & out_sat_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb1_q        <= '0;
      sb2_q        <= '0;
      p_rr_q       <= '0;
      p_ii_q       <= '0;
      p_ri_q       <= '0;
      p_ir_q       <= '0;
      re_q         <= '0;
      im_q         <= '0;
      c_r_q        <= '0;
      c_i_q        <= '0;
      out_tag_q    <= '0;
      out_sat_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      sb1_q        <= sb1_d;
      sb2_q        <= sb2_d;
      p_rr_q       <= p_rr_d;
      p_ii_q       <= p_ii_d;
      p_ri_q       <= p_ri_d;
      p_ir_q       <= p_ir_d;
      re_q         <= re_d;
      im_q         <= im_d;
      c_r_q        <= c_r_d;
      c_i_q        <= c_i_d;
      out_tag_q    <= out_tag_d;
      out_sat_q    <= out_sat_d;
      out_valid_q  <= out_valid_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Conj and the spare tag bits are dead once the sums are formed.
  assign unused_sb = &{1'b0, sb2_q.conj, sb2_q.tag};

  assign out_valid  = out_valid_q;
  assign c_r        = c_r_q;
  assign c_i        = c_i_q;
  assign out_tag    = out_tag_q;
  assign out_sat    = out_sat_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_complex_mul_rs.sv
// Scoreboard bench for complex_mul_rs: directed vectors with hand-computed results.
`timescale 1ns/1ps
module tb_complex_mul_rs;

  localparam int DW  = 21;
  localparam int TW  = 16;
  localparam int OW  = 21;
  localparam int SH  = 15;
  localparam int TGW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 conj_b;
  logic signed [DW-1:0] a_r, a_i;
  logic signed [TW-1:0] b_r, b_i;
  logic [TGW-1:0]       in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] c_r, c_i;
  logic [TGW-1:0]       out_tag;
  logic                 out_sat;
  logic                 ovf_sticky;
  logic                 ovf_clr;

  always #5 clk = ~clk;

  complex_mul_rs #(
    .DATA_WIDTH(DW), .TWID_WIDTH(TW), .OUT_WIDTH(OW), .SHIFT(SH), .TAG_WIDTH(TGW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .conj_b     (conj_b),
    .a_r        (a_r),
    .a_i        (a_i),
    .b_r        (b_r),
    .b_i        (b_i),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_r        (c_r),
    .c_i        (c_i),
    .out_tag    (out_tag),
    .out_sat    (out_sat),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  typedef struct {
    int cr;
    int ci;
    int tag;
    int sat;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;
  int   n_rx;
  int   cyc;
  int   ready_mode;
  bit   chk_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // out_ready: 0 = held high, 1 = random, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the expected entry whenever a transfer is about to happen.
  initial begin
    exp_t                 e;
    bit                   prev_stall;
    logic signed [OW-1:0] s_cr, s_ci;
    logic [TGW-1:0]       s_tag;
    logic                 s_sat;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_c_r", c_r, s_cr);
          chk("stall_c_i", c_i, s_ci);
          chk("stall_tag", out_tag, s_tag);
          chk("stall_sat", out_sat, s_sat);
        end
        if (out_valid) begin
          if (!prev_stall) begin
            if (exp_q.size() == 0)
              chk("spurious_out", out_valid, 0);
            else if (chk_lat)
              chk("latency", cyc - exp_q[0].cyc, 3);
          end
          if (out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("c_r", c_r, e.cr);
            chk("c_i", c_i, e.ci);
            chk("out_tag", out_tag, e.tag);
            chk("out_sat", out_sat, e.sat);
            n_rx++;
          end
          prev_stall = !out_ready;
          s_cr  = c_r;
          s_ci  = c_i;
          s_tag = out_tag;
          s_sat = out_sat;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  task automatic send(input int ar, input int ai, input int br, input int bi, input bit cj,
                      input int tg, input int ecr, input int eci, input int esat);
    int w;
    @(negedge clk);
    #1;
    a_r      = DW'(ar);
    a_i      = DW'(ai);
    b_r      = TW'(br);
    b_i      = TW'(bi);
    conj_b   = cj;
    in_tag   = TGW'(tg);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    else exp_q.push_back('{ecr, eci, tg, esat, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      #2;
      w++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    bit seen;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    conj_b     = 1'b0;
    a_r        = '0;
    a_i        = '0;
    b_r        = '0;
    b_i        = '0;
    in_tag     = '0;
    ovf_clr    = 1'b0;
    ready_mode = 0;
    chk_lat    = 1'b1;

    @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c_r", c_r, 0);
    chk("rst_c_i", c_i, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    chk("rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;

    // b = 0.5: basic, rounding ties, conjugate
    send(1000, 2000, 16384, 0, 1'b0, 1, 500, 1000, 0);
    send(3, 0, 16384, 0, 1'b0, 2, 2, 0, 0);
    send(-3, 0, 16384, 0, 1'b0, 3, -1, 0, 0);
    send(100, 200, 16384, 16384, 1'b0, 4, -50, 150, 0);
    send(100, 200, 16384, 16384, 1'b1, 5, 150, 50, 0);
    drain();
    chk("sticky_idle", ovf_sticky, 0);

    // (-1.0)*(-1.0) overflows the output range
    send(-1048576, 0, -32768, 0, 1'b0, 6, 1048575, 0, 1);
    drain();
    #2;
    chk("sticky_set", ovf_sticky, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    #2;
    ovf_clr = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);

    send(0, -1048576, -32768, 0, 1'b0, 7, 0, 1048575, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = out_valid && out_sat;
    end
    chk("sat_seen", seen, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    #2;
    ovf_clr = 1'b0;
    chk("sticky_clr_wins", ovf_sticky, 0);
    drain();

    // Random backpressure and input bubbles; result is a/2
    chk_lat    = 1'b0;
    ready_mode = 1;
    rx0        = n_rx;
    for (int t = 0; t < 16; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(t * 8, -t * 4, 16384, 0, 1'b0, t, t * 4, -t * 2, 0);
    end
    drain();
    chk("stream_count", n_rx - rx0, 16);

    // Three samples in flight behind a stalled output, then reset
    ready_mode = 2;
    @(negedge clk);
    send(1000, 2000, 16384, 0, 1'b0, 20, 500, 1000, 0);
    send(1000, 2000, 16384, 0, 1'b0, 21, 500, 1000, 0);
    send(1000, 2000, 16384, 0, 1'b0, 22, 500, 1000, 0);
    @(negedge clk);
    chk("stalled_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #3;
    rst_n      = 1'b1;
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      chk("postrst_out_valid", out_valid, 0);
      chk("postrst_in_ready", in_ready, 1);
    end

    ready_mode = 0;
    chk_lat    = 1'b1;
    @(negedge clk);
    send(-1000, 300, 0, 16384, 1'b1, 30, 150, 500, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
